// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the shared GPR write port, with registered writeback and a per-GPR pending scoreboard.
// Optional conflict counter enabled by defining RF_ARB_PERF_EN.
module rf_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_wreg,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_reg,
  input  logic [AW-1:0]        rs,
  input  logic [AW-1:0]        rt,
  output logic                 rs_busy,
  output logic                 rt_busy,
  output logic                 rf_wen,
  output logic [AW-1:0]        rf_wreg,
  output logic [DW-1:0]        rf_wdata,
  output logic [31:0]          perf_conflict
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NGPR = 1 << AW;

  logic [NREQ-1:0][AW-1:0] wreg;
  logic [NREQ-1:0][DW-1:0] wdata;
  logic [PW-1:0]           ptr, gidx, ptr_nxt;
  logic [NREQ-1:0]         grant;
  logic                    found, xfer;
  logic [AW-1:0]           sel_wreg;
  logic [DW-1:0]           sel_wdata;
  logic [NGPR-1:0]         pend, pend_nxt;

  assign wreg  = req_wreg;
  assign wdata = req_wdata;

  // Scan starting at ptr so the last winner drops to lowest priority.
  always_comb begin
    int idx;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  assign xfer      = found & ~reset;
  assign req_ready = reset ? '0 : grant;
  assign sel_wreg  = wreg[gidx];
  assign sel_wdata = wdata[gidx];
  assign ptr_nxt   = (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      rf_wen   <= 1'b0;
      rf_wreg  <= '0;
      rf_wdata <= '0;
    end else if (xfer) begin
      ptr      <= ptr_nxt;
      rf_wen   <= (sel_wreg != '0);
      rf_wreg  <= sel_wreg;
      rf_wdata <= sel_wdata;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Set is applied after clear so a same-edge reissue keeps the bit for the new producer.
  always_comb begin
    pend_nxt = pend;
    if (xfer) pend_nxt[sel_wreg] = 1'b0;
    if (iss_valid) pend_nxt[iss_reg] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) pend <= '0;
    else       pend <= pend_nxt;
  end

  assign rs_busy = (rs != '0) && pend[rs];
  assign rt_busy = (rt != '0) && pend[rt];

`ifdef RF_ARB_PERF_EN
  logic [31:0] conf_cnt;
  logic        multi;

  assign multi = ($countones(req_valid) >= 2);

  always_ff @(posedge clk) begin
    if (reset)                          conf_cnt <= '0;
    else if (multi && conf_cnt != '1)   conf_cnt <= conf_cnt + 32'd1;
  end

  assign perf_conflict = conf_cnt;
`else
  assign perf_conflict = 32'h0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grants and busy flags checked inline, writebacks checked by a scoreboard monitor.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_wreg;
  logic [95:0] req_wdata;
  logic        iss_valid;
  logic [4:0]  iss_reg, rs, rt;
  logic        rs_busy, rt_busy, rf_wen;
  logic [4:0]  rf_wreg;
  logic [31:0] rf_wdata, perf_conflict;

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] wdata;
  } wb_t;

  wb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  exp_conf = 0;

  rf_wb_arbiter #(.NREQ(3), .DW(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wreg(req_wreg), .req_wdata(req_wdata),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .rs(rs), .rt(rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .rf_wen(rf_wen), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .perf_conflict(perf_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) exp_conf = 0;
    else if ($countones(req_valid) >= 2) exp_conf++;
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] r, input logic [31:0] d);
    req_valid[i]         = v;
    req_wreg[i*5 +: 5]   = r;
    req_wdata[i*32 +: 32] = d;
  endtask

  task automatic push(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back({r, d});
  endtask

  function automatic logic [31:0] exp_perf();
`ifdef RF_ARB_PERF_EN
    return 32'(exp_conf);
`else
    return 32'h0;
`endif
  endfunction

  // Scoreboard monitor: every register-file write must match the oldest expected one.
  always @(negedge clk) begin
    if (rf_wen === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got wreg=%0d data=%h expected no write", rf_wreg, rf_wdata);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        if (rf_wreg !== e.wreg || rf_wdata !== e.wdata) begin
          errors++;
          $display("FAIL sb_write: got wreg=%0d data=%h expected wreg=%0d data=%h",
                   rf_wreg, rf_wdata, e.wreg, e.wdata);
        end
      end
    end
  end

  initial begin
    logic [2:0] g2 [4];
    logic [4:0] r2 [4];
    g2 = '{3'b001, 3'b010, 3'b100, 3'b001};
    r2 = '{5'd1, 5'd2, 5'd3, 5'd1};

    reset = 1'b1; req_valid = '0; req_wreg = '0; req_wdata = '0;
    iss_valid = 1'b0; iss_reg = '0; rs = '0; rt = '0;
    tick(); tick();
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_wen", 32'(rf_wen), 32'h0);
    chk("rst_wreg", 32'(rf_wreg), 32'h0);
    chk("rst_wdata", rf_wdata, 32'h0);
    chk("rst_perf", perf_conflict, 32'h0);
    tick();
    reset = 1'b0;

    // All three held valid: rotating grants from requester 0
    set_req(0, 1'b1, 5'd1, 32'hA1);
    set_req(1, 1'b1, 5'd2, 32'hA2);
    set_req(2, 1'b1, 5'd3, 32'hA3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(g2[k]));
      push(r2[k], 32'hA0 + 32'(r2[k]));
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("rr_perf", perf_conflict, exp_perf());
    tick();

    // Single requester 0 (ptr now 1)
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    push(5'd5, 32'hDEADBEEF);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("single_wen", 32'(rf_wen), 32'h1);
    chk("single_wreg", 32'(rf_wreg), 32'd5);
    chk("single_wdata", rf_wdata, 32'hDEADBEEF);
    tick();

    // RAW scoreboard on GPR7
    iss_valid = 1'b1; iss_reg = 5'd7; rs = 5'd7;
    @(negedge clk);
    chk("raw_busy_before", 32'(rs_busy), 32'h0);
    tick();
    iss_valid = 1'b0;
    set_req(1, 1'b1, 5'd7, 32'h77);
    @(negedge clk);
    chk("raw_busy_set", 32'(rs_busy), 32'h1);
    chk("raw_ready", 32'(req_ready), 32'h2);
    push(5'd7, 32'h77);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("raw_busy_clr", 32'(rs_busy), 32'h0);
    chk("raw_wen", 32'(rf_wen), 32'h1);
    chk("raw_wreg", 32'(rf_wreg), 32'd7);
    tick();

    // Same-edge clear and set of GPR9: set wins
    set_req(2, 1'b1, 5'd9, 32'h99);
    iss_valid = 1'b1; iss_reg = 5'd9; rt = 5'd9;
    @(negedge clk);
    chk("ss_ready", 32'(req_ready), 32'h4);
    chk("ss_busy_before", 32'(rt_busy), 32'h0);
    push(5'd9, 32'h99);
    tick();
    req_valid = '0; iss_valid = 1'b0;
    @(negedge clk);
    chk("ss_busy_after", 32'(rt_busy), 32'h1);
    tick();

    // GPR0 write accepted and dropped; GPR0 never busy
    set_req(0, 1'b1, 5'd0, 32'h55);
    iss_valid = 1'b1; iss_reg = 5'd0; rs = 5'd0;
    @(negedge clk);
    chk("z_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0; iss_valid = 1'b0;
    @(negedge clk);
    chk("z_wen", 32'(rf_wen), 32'h0);
    chk("z_busy", 32'(rs_busy), 32'h0);
    tick();

    // Two contenders with ptr=1: requester 2 first, then 0
    set_req(0, 1'b1, 5'd11, 32'hB0);
    set_req(2, 1'b1, 5'd10, 32'hB2);
    @(negedge clk);
    chk("rr2_first", 32'(req_ready), 32'h4);
    push(5'd10, 32'hB2);
    tick();
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("rr2_second", 32'(req_ready), 32'h1);
    push(5'd11, 32'hB0);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("rr2_perf", perf_conflict, exp_perf());
    tick();

    // Reset mid-operation with pending bits and all requesters valid
    iss_valid = 1'b1; iss_reg = 5'd12;
    tick();
    iss_valid = 1'b0; rs = 5'd12; rt = 5'd9;
    @(negedge clk);
    chk("mr_rs_busy", 32'(rs_busy), 32'h1);
    chk("mr_rt_busy", 32'(rt_busy), 32'h1);
    tick();
    reset = 1'b1;
    set_req(0, 1'b1, 5'd13, 32'hC0);
    set_req(1, 1'b1, 5'd14, 32'hC1);
    set_req(2, 1'b1, 5'd15, 32'hC2);
    @(negedge clk);
    chk("mr_ready", 32'(req_ready), 32'h0);
    tick();
    reset = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("mr_wen", 32'(rf_wen), 32'h0);
    chk("mr_rs_clr", 32'(rs_busy), 32'h0);
    chk("mr_rt_clr", 32'(rt_busy), 32'h0);
    chk("mr_perf", perf_conflict, 32'h0);
    tick();

    // Ten conflict cycles on dropped GPR0 writes; grants alternate from 0
    set_req(0, 1'b1, 5'd0, 32'hE0);
    set_req(1, 1'b1, 5'd0, 32'hE1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("conf_grant%0d", k), 32'(req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
      tick();
    end
    req_valid = '0;
    @(negedge clk);
    chk("conf_perf", perf_conflict, exp_perf());
    tick();

    @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
